multiport_register_file: RTL
============================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 1, number of write ports (1..2).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_ena, input, NWR, per-port write enable.
REQ-008 SHALL have port wr_addr, input, NWR x AW, per-port write address.
REQ-009 SHALL have port wr_data, input, NWR x XLEN, per-port write data.
REQ-010 SHALL have port rd_addr, input, NRD x AW, per-port read address.
REQ-011 SHALL have port rd_data, output, NRD x XLEN, per-port read data (combinational).
REQ-012 SHALL have port clr_req, input, 1, request a sequential clear of all registers.
REQ-013 SHALL have port clr_busy, output, 1, high while a clear sweep is in progress.
REQ-014 SHALL have port clr_done, output, 1, single-cycle pulse when a sweep completes.
REQ-015 SHALL have port wr_conflict, output, 1, registered pulse: two ports wrote the same nonzero address.

Function
REQ-016 SHALL hardwire register 0 to zero: writes to address 0 are discarded, reads of address 0 return 0.
REQ-017 SHALL write enabled, non-stalled ports into storage at the rising edge; new value is visible one cycle later (no bypass unless REQ-030).
REQ-018 SHALL resolve two write ports to the same nonzero address in favour of port 1, and assert wr_conflict the following cycle for one cycle.
REQ-019 SHALL implement a clear FSM with states IDLE, CLEAR and DONE.
REQ-020 IDLE -> CLEAR when clr_req=1; clear index loads 1; clr_busy=1 from the next cycle.
REQ-021 CLEAR SHALL zero one register per cycle (index 1..NREGS-1, incrementing), taking NREGS-1 cycles, then go to DONE.
REQ-022 DONE SHALL assert clr_done for exactly one cycle, deassert clr_busy, and return to IDLE.
REQ-023 SHALL ignore all write ports while clr_busy=1, without conflict reporting.
REQ-024 SHALL ignore clr_req outside IDLE; clr_req held high in DONE SHALL start a new sweep on the cycle after returning to IDLE.
REQ-025 SHALL serve reads during CLEAR from current storage: swept indices return 0, unswept indices return their old values.

Reset
REQ-026 On rst low, all registers, the FSM (IDLE), the clear index, clr_busy, clr_done and wr_conflict SHALL go to 0 immediately, independent of clk.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep; after release the FSM is IDLE with no clr_done pulse.
REQ-028 rd_data SHALL read 0 on every port while rst is low.

Configuration
REQ-029 SHALL recognise the macro RF_BYPASS_EN.
REQ-030 When RF_BYPASS_EN is defined, a read matching an accepted same-cycle write address (nonzero, not stalled) SHALL return that wr_data, with the port-1 priority of REQ-018; when it is undefined, reads return stored values only (REQ-017).

Structure
REQ-031 Package rf_pkg SHALL hold the FSM state enum (IDLE, CLEAR, DONE) and the default constants for XLEN, NREGS, NRD and NWR.
REQ-032 The FSM and clear index SHALL live in the sub-module rf_clear_sequencer (outputs clr_busy, clr_done, clear index, clear strobe); storage, decode and read muxes stay in the top module.

Verification
REQ-033 Write 0xDEADBEEF to x5 via port 0, then read x5 on rd port 1 the next cycle -> 0xDEADBEEF; write 0x1234 to x0 -> x0 reads 0.
REQ-034 NWR=2: same cycle port0 x7=0xAAAA and port1 x7=0x5555 -> x7=0x5555, wr_conflict=1 for exactly one cycle after the write.
REQ-035 Fill x1..x31 with their index, pulse clr_req -> clr_busy for 31 cycles, x3 reads 0 after its sweep cycle while x20 still reads 20, then one clr_done pulse and all registers read 0.
REQ-036 During a sweep, write x9=0xFF -> write ignored; x9 reads 0 after the sweep.
REQ-037 RF_BYPASS_EN defined: write x4=0xCAFE with rd_addr=4 in the same cycle -> rd_data=0xCAFE that cycle; undefined -> old x4 value that cycle, 0xCAFE the next.
REQ-038 Assert rst low at sweep cycle 10 -> all outputs 0 immediately; after release FSM is IDLE, no clr_done, and writes are accepted.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multiport register file.
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_NRD   = 2;
  localparam int RF_NWR   = 1;

endpackage

// File: rtl/rf_clear_sequencer.sv
// Clear-sweep FSM: walks registers 1..NREGS-1, zeroing one register per cycle,
// then pulses done for one cycle.
module rf_clear_sequencer
  import rf_pkg::*;
#(
  parameter  int NREGS = RF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clrReq,
  output logic          o_clrBusy,
  output logic          o_clrDone,
  output logic [AW-1:0] o_clrIdx,
  output logic          o_clrStrobe
);

  clr_state_e    r_state;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_idx;

  // Busy and done are registered so they line up exactly with the CLEAR and DONE states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_clrReq) begin
            r_state <= CLEAR;
            r_idx   <= AW'(1);
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_idx == AW'(NREGS - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clrBusy   = r_busy;
  assign o_clrDone   = r_done;
  assign o_clrIdx    = r_idx;
  assign o_clrStrobe = r_busy;

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file with hardwired x0, port-1 write priority and a sequential clear.
// Define RF_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module multiport_register_file
  import rf_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN,
  parameter  int NREGS = RF_NREGS,
  parameter  int NRD   = RF_NRD,
  parameter  int NWR   = RF_NWR,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NWR-1:0]            wr_ena,
  input  logic [NWR-1:0][AW-1:0]    wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      wr_conflict
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_conflict;
  logic            w_clrStrobe;
  logic [AW-1:0]   w_clrIdx;
  logic [NWR-1:0]  w_wrAcc;
  logic            w_conflict;

  rf_clear_sequencer #(.NREGS(NREGS)) u_clearSeq (
    .clk         (clk),
    .rst         (rst),
    .i_clrReq    (clr_req),
    .o_clrBusy   (clr_busy),
    .o_clrDone   (clr_done),
    .o_clrIdx    (w_clrIdx),
    .o_clrStrobe (w_clrStrobe)
  );

  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      w_wrAcc[p] = wr_ena[p] && (wr_addr[p] != '0) && !clr_busy;
    end
  end

  if (NWR > 1) begin : g_conflict
    assign w_conflict = w_wrAcc[0] && w_wrAcc[1] && (wr_addr[0] == wr_addr[1]);
  end else begin : g_noConflict
    assign w_conflict = 1'b0;
  end

  // Later ports are applied last so port 1 wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_clrStrobe) begin
      r_regs[w_clrIdx] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (w_wrAcc[p]) begin
          r_regs[wr_addr[p]] <= wr_data[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
    end
  end

  assign wr_conflict = r_conflict;

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_data[r] = '0;
      if (rst && (rd_addr[r] != '0)) begin
        rd_data[r] = r_regs[rd_addr[r]];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (w_wrAcc[p] && (wr_addr[p] == rd_addr[r])) begin
            rd_data[r] = wr_data[p];
          end
        end
`else
`endif
      end
    end
  end

endmodule
